// File: rtl/sem_mon_parser_if.sv
// Read-side handshake between the SEM monitor TX FIFO and the line parser.
// The FIFO has no output register, so FF_DATA is valid the cycle after FF_RD.
interface sem_mon_parser_if;
   logic [7:0] FF_DATA;
   logic       FF_EMPTY;
   logic       FF_RD;

   modport master (
      input  FF_DATA,
      input  FF_EMPTY,
      output FF_RD
   );

   modport slave (
      output FF_DATA,
      output FF_EMPTY,
      input  FF_RD
   );
endinterface

// File: rtl/sem_mon_parser.sv
// Parses "SC <2 hex>" and "FA <FAR_DIGITS hex>" lines from the SEM monitor
// byte stream, latching valid fields and counting terminated and malformed lines.
module sem_mon_parser #(
   parameter int unsigned FAR_DIGITS = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    CLK40,
   input  logic                    RST_B,
   sem_mon_parser_if.master        ff,
   input  logic                    PARSE_EN,
   input  logic                    CNT_CLR,
   output logic [7:0]              SC_CODE,
   output logic                    SC_STB,
   output logic [4*FAR_DIGITS-1:0] FAR_VAL,
   output logic                    FAR_STB,
   output logic [CNT_W-1:0]        LINE_CNT,
   output logic [7:0]              BAD_CNT,
   output logic                    BUSY
);

   localparam int unsigned AccW = 4 * FAR_DIGITS;
   localparam int unsigned DcW  = $clog2(FAR_DIGITS + 2);
   localparam logic [DcW-1:0] ScLim = DcW'(2);
   localparam logic [DcW-1:0] FaLim = DcW'(FAR_DIGITS);

   typedef enum logic [2:0] {
      StIdle, StKS, StKF, StSpSc, StSpFa, StHexSc, StHexFa, StSkip
   } state_e;

   state_e            state_q, state_d;
   logic              rd_d1_q;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [DcW-1:0]    dcnt_q, dcnt_d;
   logic [7:0]        sc_q, sc_d;
   logic [AccW-1:0]   far_q, far_d;
   logic              sc_stb_q, sc_stb_d;
   logic              far_stb_q, far_stb_d;
   logic [CNT_W-1:0]  line_q, line_d;
   logic [7:0]        bad_q, bad_d;

   logic       line_inc, bad_inc;
   logic       is_hex, is_cr, is_sp, is_lf;
   logic [3:0] hex_val;
   logic [DcW-1:0] limit;
   logic [7:0] data;

   assign ff.FF_RD = PARSE_EN & ~ff.FF_EMPTY;
   assign data     = ff.FF_DATA;

   always_comb begin
      is_hex  = 1'b0;
      hex_val = 4'h0;
      if (data >= 8'h30 && data <= 8'h39) begin
         is_hex  = 1'b1;
         hex_val = data[3:0];
      end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 maps them to 10.
         is_hex  = 1'b1;
         hex_val = data[3:0] + 4'd9;
      end
   end

   assign is_cr = (data == 8'h0D);
   assign is_sp = (data == 8'h20);
   assign is_lf = (data == 8'h0A);
   assign limit = (state_q == StHexSc) ? ScLim : FaLim;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      dcnt_d    = dcnt_q;
      sc_d      = sc_q;
      far_d     = far_q;
      sc_stb_d  = 1'b0;
      far_stb_d = 1'b0;
      line_inc  = 1'b0;
      bad_inc   = 1'b0;

      if (rd_d1_q && !is_lf) begin
         if (is_cr && state_q != StIdle) line_inc = 1'b1;
         unique case (state_q)
            StIdle: begin
               if (data == 8'h53)      state_d = StKS;
               else if (data == 8'h46) state_d = StKF;
               else if (is_cr)         state_d = StIdle;
               else                    state_d = StSkip;
            end
            StKS: begin
               if (data == 8'h43) state_d = StSpSc;
               else if (is_cr)    state_d = StIdle;
               else               state_d = StSkip;
            end
            StKF: begin
               if (data == 8'h41) state_d = StSpFa;
               else if (is_cr)    state_d = StIdle;
               else               state_d = StSkip;
            end
            StSpSc, StSpFa: begin
               if (is_sp) begin
                  acc_d   = '0;
                  dcnt_d  = '0;
                  state_d = (state_q == StSpSc) ? StHexSc : StHexFa;
               end else if (is_cr) begin
                  state_d = StIdle;
               end else begin
                  state_d = StSkip;
               end
            end
            StHexSc, StHexFa: begin
               if (is_hex) begin
                  if (dcnt_q == limit) begin
                     bad_inc = 1'b1;
                     state_d = StSkip;
                  end else begin
                     acc_d  = {acc_q[AccW-5:0], hex_val};
                     dcnt_d = dcnt_q + DcW'(1);
                  end
               end else if (is_cr || is_sp) begin
                  if (dcnt_q != limit) begin
                     bad_inc = 1'b1;
                  end else if (state_q == StHexSc) begin
                     sc_d     = acc_q[7:0];
                     sc_stb_d = 1'b1;
                  end else begin
                     far_d     = acc_q;
                     far_stb_d = 1'b1;
                  end
                  state_d = is_cr ? StIdle : StSkip;
               end else begin
                  bad_inc = 1'b1;
                  state_d = StSkip;
               end
            end
            StSkip: begin
               if (is_cr) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Clear wins over a same-cycle increment; both counters saturate.
      line_d = line_q;
      if (CNT_CLR)                    line_d = '0;
      else if (line_inc && ~&line_q)  line_d = line_q + CNT_W'(1);
      bad_d = bad_q;
      if (CNT_CLR)                    bad_d = '0;
      else if (bad_inc && ~&bad_q)    bad_d = bad_q + 8'd1;
   end

   always_ff @(posedge CLK40 or negedge RST_B) begin
      if (!RST_B) begin
         state_q   <= StIdle;
         rd_d1_q   <= 1'b0;
         acc_q     <= '0;
         dcnt_q    <= '0;
         sc_q      <= 8'h00;
         far_q     <= '0;
         sc_stb_q  <= 1'b0;
         far_stb_q <= 1'b0;
         line_q    <= '0;
         bad_q     <= 8'h00;
      end else begin
         state_q   <= state_d;
         rd_d1_q   <= ff.FF_RD;
         acc_q     <= acc_d;
         dcnt_q    <= dcnt_d;
         sc_q      <= sc_d;
         far_q     <= far_d;
         sc_stb_q  <= sc_stb_d;
         far_stb_q <= far_stb_d;
         line_q    <= line_d;
         bad_q     <= bad_d;
      end
   end

   assign SC_CODE  = sc_q;
   assign SC_STB   = sc_stb_q;
   assign FAR_VAL  = far_q;
   assign FAR_STB  = far_stb_q;
   assign LINE_CNT = line_q;
   assign BAD_CNT  = bad_q;
   assign BUSY     = (state_q != StIdle) | rd_d1_q;

endmodule

// File: tb/tb_sem_mon_parser.sv
// Directed bench for sem_mon_parser: a behavioural FIFO feeds byte strings and
// each result is checked against hand-computed values.
`timescale 1ns/1ps
module tb_sem_mon_parser;
   localparam int unsigned CntW = 10;

   logic            CLK40 = 1'b0;
   logic            RST_B = 1'b0;
   logic            PARSE_EN = 1'b0;
   logic            CNT_CLR = 1'b0;
   logic [7:0]      SC_CODE;
   logic            SC_STB;
   logic [31:0]     FAR_VAL;
   logic            FAR_STB;
   logic [CntW-1:0] LINE_CNT;
   logic [7:0]      BAD_CNT;
   logic            BUSY;

   sem_mon_parser_if bus ();

   sem_mon_parser #(.FAR_DIGITS(8), .CNT_W(CntW)) dut (
      .CLK40    (CLK40),
      .RST_B    (RST_B),
      .ff       (bus.master),
      .PARSE_EN (PARSE_EN),
      .CNT_CLR  (CNT_CLR),
      .SC_CODE  (SC_CODE),
      .SC_STB   (SC_STB),
      .FAR_VAL  (FAR_VAL),
      .FAR_STB  (FAR_STB),
      .LINE_CNT (LINE_CNT),
      .BAD_CNT  (BAD_CNT),
      .BUSY     (BUSY)
   );

   always #12.5 CLK40 = ~CLK40;

   logic [7:0]  mem [0:4095];
   logic [11:0] wr_ptr = '0;
   logic [11:0] rd_ptr = '0;
   logic        force_empty = 1'b0;

   assign bus.FF_EMPTY = (wr_ptr == rd_ptr) || force_empty;

   always @(posedge CLK40) begin
      if (bus.FF_RD) begin
         bus.FF_DATA <= mem[rd_ptr];
         rd_ptr      <= rd_ptr + 12'd1;
      end
   end

   int cyc = 0, cr_cyc = 0, sc_cyc = 0, sc_pulses = 0, far_pulses = 0;
   always @(negedge CLK40) begin
      cyc <= cyc + 1;
      if (bus.FF_RD && mem[rd_ptr] == 8'h0D) cr_cyc <= cyc;
      if (SC_STB) begin
         sc_pulses <= sc_pulses + 1;
         sc_cyc    <= cyc;
      end
      if (FAR_STB) far_pulses <= far_pulses + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         mem[wr_ptr] = s[i];
         wr_ptr      = wr_ptr + 12'd1;
      end
   endtask

   task automatic run_fifo(input int budget);
      int n = 0;
      PARSE_EN = 1'b1;
      do begin
         @(negedge CLK40);
         n++;
      end while (!(wr_ptr == rd_ptr && !BUSY) && n <= budget);
      if (n > budget) check("drain_timeout", 64'd1, 64'd0);
      PARSE_EN = 1'b0;
      repeat (3) @(negedge CLK40);
      #1;
   endtask

   task automatic do_reset();
      PARSE_EN = 1'b0;
      CNT_CLR  = 1'b0;
      RST_B    = 1'b0;
      repeat (2) @(negedge CLK40);
      RST_B = 1'b1;
      @(negedge CLK40);
      #1;
   endtask

   int sc0, far0;

   initial begin
      do_reset();
      check("rst_sc_code", SC_CODE, 8'h00);
      check("rst_far_val", FAR_VAL, 32'h0);
      check("rst_line", LINE_CNT, 0);
      check("rst_bad", BAD_CNT, 8'h00);
      check("rst_busy", BUSY, 1'b0);
      check("rst_strobes", {SC_STB, FAR_STB}, 2'b00);

      // Valid status-change line.
      sc0 = sc_pulses;
      push_str("SC 04\r");
      run_fifo(100);
      check("sc_code", SC_CODE, 8'h04);
      check("sc_pulses", sc_pulses - sc0, 1);
      check("sc_latency", sc_cyc - cr_cyc, 2);
      check("sc_line", LINE_CNT, 1);
      check("sc_bad", BAD_CNT, 0);

      // Frame address with lowercase digit and trailing LF.
      do_reset();
      far0 = far_pulses;
      push_str("FA 0040AB1f\r\n");
      run_fifo(100);
      check("far_val", FAR_VAL, 32'h0040AB1F);
      check("far_pulses", far_pulses - far0, 1);
      check("far_line", LINE_CNT, 1);
      check("far_bad", BAD_CNT, 0);

      // Short, long and non-hex SC fields.
      do_reset();
      sc0 = sc_pulses;
      push_str("SC 4\rSC 123\rSC 0G\r");
      run_fifo(200);
      check("bad3_bad", BAD_CNT, 3);
      check("bad3_sc_code", SC_CODE, 8'h00);
      check("bad3_pulses", sc_pulses - sc0, 0);
      check("bad3_line", LINE_CNT, 3);

      // Unknown line and empty line.
      do_reset();
      sc0 = sc_pulses;
      far0 = far_pulses;
      push_str("O>\r\r");
      run_fifo(100);
      check("other_line", LINE_CNT, 1);
      check("other_bad", BAD_CNT, 0);
      check("other_pulses", (sc_pulses - sc0) + (far_pulses - far0), 0);

      // Toggling empty must gate every read.
      do_reset();
      push_str("SC 55\r");
      PARSE_EN = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK40);
         force_empty = ~force_empty;
         #1;
         check("rd_while_empty", bus.FF_RD & bus.FF_EMPTY, 1'b0);
      end
      force_empty = 1'b0;
      run_fifo(100);
      check("toggle_sc_code", SC_CODE, 8'h55);

      // Line counter saturation, then clear racing a CR.
      do_reset();
      for (int i = 0; i < 1023; i++) push_str("X\r");
      run_fifo(5000);
      check("sat_full", LINE_CNT, 10'h3FF);
      push_str("X\r");
      run_fifo(100);
      check("sat_hold", LINE_CNT, 10'h3FF);
      push_str("X\r");
      @(negedge CLK40);
      PARSE_EN = 1'b1;
      @(negedge CLK40);
      @(negedge CLK40);
      CNT_CLR = 1'b1;
      @(negedge CLK40);
      CNT_CLR = 1'b0;
      run_fifo(100);
      check("clr_vs_cr", LINE_CNT, 0);
      check("clr_bad", BAD_CNT, 0);

      // Reset in the middle of a line.
      do_reset();
      push_str("FA 12");
      PARSE_EN = 1'b1;
      repeat (10) @(negedge CLK40);
      #1;
      check("mid_busy", BUSY, 1'b1);
      RST_B = 1'b0;
      #1;
      check("mid_rst_idle", BUSY, 1'b0);
      PARSE_EN = 1'b0;
      @(negedge CLK40);
      RST_B = 1'b1;
      @(negedge CLK40);
      push_str("SC 01\r");
      run_fifo(100);
      check("mid_sc_code", SC_CODE, 8'h01);
      check("mid_far_val", FAR_VAL, 32'h0);
      check("mid_bad", BAD_CNT, 0);
      check("mid_line", LINE_CNT, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
